// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: I2S / left-justified / TDM master serial transmitter.
// Ports: clk, rst (async low), s_valid/s_ready/s_data frame input,
// sclk, lrclk, sdata serial outputs, frame_start and underrun strobes.
module i2s_tdm_tx #(
  parameter int DW       = 24,
  parameter int SLOT_W   = 32,
  parameter int NCH      = 2,
  parameter int MCLK_DIV = 4,
  parameter int MODE     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [NCH*DW-1:0] s_data,
  output logic              sclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int F   = NCH * SLOT_W;
  localparam int KW  = (F > 1) ? $clog2(F) : 1;
  localparam int DVW = $clog2(MCLK_DIV);

  localparam logic [DVW-1:0] D_LAST = DVW'(MCLK_DIV - 1);
  localparam logic [DVW-1:0] D_HALF = DVW'(MCLK_DIV / 2);
  localparam logic [KW-1:0]  K_LAST = KW'(F - 1);

  if (DW < 1 || DW > SLOT_W) begin : g_chk_dw
    $error("i2s_tdm_tx: DW must be in 1..SLOT_W");
  end
  if (NCH < 1 || (MODE != 2 && NCH != 2)) begin : g_chk_nch
    $error("i2s_tdm_tx: NCH must be 2 unless MODE is TDM");
  end
  if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_chk_div
    $error("i2s_tdm_tx: MCLK_DIV must be even and >= 2");
  end
  if (MODE < 0 || MODE > 2) begin : g_chk_mode
    $error("i2s_tdm_tx: MODE must be 0, 1 or 2");
  end

  logic [DVW-1:0]    d_q, d_nxt;
  logic [KW-1:0]     k_q, k_nxt;
  logic              d_wrap, tick, xfer;
  logic              hold_full;
  logic [NCH*DW-1:0] hold_q;
  logic [F-1:0]      sr_q, sr_nxt, fmt;
  logic [31:0]       kn;
  logic              lr_nxt;

  assign s_ready = ~hold_full;
  assign xfer    = s_valid & ~hold_full;

  always_comb begin
    d_wrap = (d_q == D_LAST);
    d_nxt  = d_wrap ? '0 : d_q + DVW'(1);
    k_nxt  = k_q;
    if (d_wrap) begin
      k_nxt = (k_q == K_LAST) ? '0 : k_q + KW'(1);
    end
    tick = d_wrap && (k_q == K_LAST);
  end

  // Frame image: bit F-1 goes out first; each slot holds
  // its channel MSB-first followed by zero padding.
  always_comb begin
    fmt = '0;
    for (int c = 0; c < NCH; c++) begin
      fmt[F-1-c*SLOT_W -: DW] = hold_q[c*DW +: DW];
    end
  end

  always_comb begin
    sr_nxt = sr_q;
    if (tick) begin
      sr_nxt = hold_full ? fmt : '0;
    end else if (d_wrap) begin
      sr_nxt = sr_q << 1;
    end
  end

  // Word select for the sclk period about to start.
  always_comb begin
    kn     = 32'(k_nxt);
    lr_nxt = 1'b0;
    unique case (1'b1)
      (MODE == 2): lr_nxt = (k_nxt == K_LAST);
      (MODE == 1): lr_nxt = (kn >= 32'(SLOT_W));
      default:     lr_nxt = (k_nxt != K_LAST) &&
                            ((kn + 32'd1) >= 32'(SLOT_W));
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q         <= '0;
      k_q         <= '0;
      sr_q        <= '0;
      sclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      d_q         <= d_nxt;
      k_q         <= k_nxt;
      sr_q        <= sr_nxt;
      sclk        <= (d_nxt >= D_HALF);
      frame_start <= tick;
      underrun    <= tick & ~hold_full;
      if (d_wrap) begin
        lrclk <= lr_nxt;
        sdata <= sr_nxt[F-1];
      end
    end
  end

  // A transfer on the tick itself only happens with hold
  // empty, so it refills hold for the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
      hold_q    <= '0;
    end else if (xfer) begin
      hold_full <= 1'b1;
      hold_q    <= s_data;
    end else if (tick) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: scoreboard bench for i2s_tdm_tx.
// Three instances: I2S, left-justified, 8-channel TDM.
module tb_i2s_tdm_tx;

  localparam int NCH_A[3]  = '{2, 2, 8};
  localparam int F_A[3]    = '{64, 64, 256};
  localparam int DIV_A[3]  = '{4, 4, 2};
  localparam int MODE_A[3] = '{0, 1, 2};
  localparam int P_A[3]    = '{256, 256, 512};

  typedef struct {
    logic [255:0] bits;
    logic         und;
  } exp_t;

  logic         clk = 1'b0;
  logic [2:0]   rst_v = 3'b111;
  logic [2:0]   sv = 3'b000;
  logic [47:0]  sd0 = '0;
  logic [47:0]  sd1 = '0;
  logic [191:0] sd2 = '0;
  logic [2:0]   rdy, sck, lr, sdo, fs, ur;
  logic [191:0] sdg [3];

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  assign sdg[0] = {144'b0, sd0};
  assign sdg[1] = {144'b0, sd1};
  assign sdg[2] = sd2;

  i2s_tdm_tx #(.MODE(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .s_valid(sv[0]),
    .s_ready(rdy[0]), .s_data(sd0), .sclk(sck[0]),
    .lrclk(lr[0]), .sdata(sdo[0]),
    .frame_start(fs[0]), .underrun(ur[0])
  );

  i2s_tdm_tx #(.MODE(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .s_valid(sv[1]),
    .s_ready(rdy[1]), .s_data(sd1), .sclk(sck[1]),
    .lrclk(lr[1]), .sdata(sdo[1]),
    .frame_start(fs[1]), .underrun(ur[1])
  );

  i2s_tdm_tx #(
    .MODE(2), .NCH(8), .SLOT_W(32), .MCLK_DIV(2)
  ) u2 (
    .clk(clk), .rst(rst_v[2]), .s_valid(sv[2]),
    .s_ready(rdy[2]), .s_data(sd2), .sclk(sck[2]),
    .lrclk(lr[2]), .sdata(sdo[2]),
    .frame_start(fs[2]), .underrun(ur[2])
  );

  function automatic void chk(string nm,
                              logic [255:0] a,
                              logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endfunction

  function automatic void push(int i, exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsz(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop(int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Expected frame bits, index k = sclk period k.
  function automatic logic [255:0] fbits(int i,
                                         logic [191:0] d);
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < NCH_A[i]; c++)
      for (int b = 0; b < 24; b++)
        r[c*32+b] = d[c*24+23-b];
    return r;
  endfunction

  function automatic logic [255:0] lrbits(int i);
    logic [255:0] r;
    int f;
    r = '0;
    f = F_A[i];
    for (int k = 0; k < f; k++) begin
      case (MODE_A[i])
        0:       r[k] = (((k + 1) % f) >= 32);
        1:       r[k] = (k >= 32);
        default: r[k] = (k == f - 1);
      endcase
    end
    return r;
  endfunction

  // Reference model: frame ticks from cycle count since reset.
  int           cyc [3];
  logic         m_full [3];
  logic [191:0] m_hold [3];
  logic [255:0] m_tx [3];

  always @(posedge clk) begin : model
    exp_t e;
    logic x;
    for (int i = 0; i < 3; i++) begin
      if (!rst_v[i]) begin
        cyc[i]    = 0;
        m_full[i] = 1'b0;
        m_tx[i]   = '0;
      end else begin
        x = sv[i] && !m_full[i];
        if (cyc[i] == P_A[i] - 1) begin
          e.bits = m_tx[i];
          e.und  = !m_full[i];
          push(i, e);
          m_tx[i]   = m_full[i] ? fbits(i, m_hold[i]) : '0;
          m_full[i] = 1'b0;
        end
        if (x) begin
          m_full[i] = 1'b1;
          m_hold[i] = sdg[i];
        end
        cyc[i] = (cyc[i] + 1) % P_A[i];
      end
    end
  end

  // Monitor: deserialise at sclk rise, check at frame_start.
  int           cnt [3];
  int           since [3];
  int           gap [3];
  int           nfs [3] = '{0, 0, 0};
  int           urn [3] = '{0, 0, 0};
  logic         had_fs [3];
  logic         psck [3];
  logic [255:0] cap [3];
  logic [255:0] lrc [3];
  logic [255:0] last [3];

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_v[i]) begin
        cnt[i]    = 0;
        since[i]  = 0;
        gap[i]    = 0;
        had_fs[i] = 1'b0;
        psck[i]   = 1'b0;
        cap[i]    = '0;
        lrc[i]    = '0;
      end else begin
        since[i]++;
        gap[i]++;
        chk("ready_vs_model", rdy[i], !m_full[i]);
        chk("underrun_off_tick", ur[i] & ~fs[i], 0);
        if (sck[i] && !psck[i]) begin
          if (cnt[i] > 0)
            chk("sclk_period", since[i], DIV_A[i]);
          since[i] = 0;
          if (cnt[i] < F_A[i]) begin
            cap[i][cnt[i]] = sdo[i];
            lrc[i][cnt[i]] = lr[i];
          end
          cnt[i]++;
        end
        psck[i] = sck[i];
        if (ur[i]) urn[i]++;
        if (fs[i]) begin
          if (had_fs[i])
            chk("frame_period", gap[i], P_A[i]);
          gap[i]    = 0;
          had_fs[i] = 1'b1;
          if (qsz(i) == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = pop(i);
            chk("frame_data", cap[i], e.bits);
            chk("frame_lrclk", lrc[i], lrbits(i));
            chk("frame_underrun", ur[i], e.und);
            chk("frame_bits", cnt[i], F_A[i]);
          end
          last[i] = cap[i];
          nfs[i]++;
          cnt[i] = 0;
          cap[i] = '0;
          lrc[i] = '0;
        end
      end
    end
  end

  task automatic wait_fs(int i, int n);
    int tgt;
    int lim;
    tgt = nfs[i] + n;
    lim = 0;
    while (nfs[i] < tgt && lim < n * 600) begin
      @(negedge clk);
      #1;
      lim++;
    end
    if (nfs[i] < tgt) chk("wait_frame_timeout", 0, 1);
  endtask

  initial begin
    int u;
    #1 rst_v = 3'b000;
    #1;
    chk("reset_outs", {sck, lr, sdo, fs, ur}, 0);
    chk("reset_ready", rdy, 3'b111);

    sd0 = {24'h000001, 24'h800000};
    sd1 = {24'h000001, 24'h800000};
    for (int c = 0; c < 8; c++) sd2[c*24 +: 24] = 24'(c + 1);
    sv = 3'b111;
    repeat (3) @(negedge clk);
    rst_v = 3'b111;

    wait_fs(0, 3);
    chk("i2s_frame", last[0], 256'h0080_0000_0000_0001);
    chk("lj_frame", last[1], 256'h0080_0000_0000_0001);

    sd0 = {24'h123456, 24'hABCDEF};
    @(negedge clk);
    sv[0] = 1'b0;
    wait_fs(0, 1);
    u = urn[0];
    wait_fs(0, 3);
    chk("underrun_count", urn[0] - u, 3);

    repeat (P_A[0] - 1) @(negedge clk);
    sd0   = {24'h000F00, 24'h5A5A5A};
    sv[0] = 1'b1;
    @(negedge clk);
    chk("tick_xfer", {fs[0], ur[0], rdy[0]}, 3'b110);
    #1;
    sv[0] = 1'b0;
    wait_fs(0, 2);

    sd0   = {24'h000001, 24'hFFFFFF};
    sv[0] = 1'b1;
    wait_fs(0, 2);
    repeat (70) @(negedge clk);
    chk("pre_reset", {sck[0], sdo[0], rdy[0]}, 3'b110);
    #2 rst_v[0] = 1'b0;
    #1;
    chk("reset_async",
        {sck[0], lr[0], sdo[0], fs[0], ur[0], rdy[0]},
        6'b000001);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    u = urn[0];
    wait_fs(0, 1);
    chk("silent_first", last[0], 0);
    chk("no_underrun_after_reset", urn[0] - u, 0);
    wait_fs(0, 2);

    chk("tdm_frames_seen", nfs[2] >= 5, 1);
    @(negedge clk);
    #1;
    chk("queues_drained", qsz(0) + qsz(1) + qsz(2), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
